// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
// Shared definitions for the instruction-fetch run/step sequencer:
//   - STATE_BITS        : width of the FSM state encoding
//   - DEFAULT_HALT_WORD : encoding that stops fetch when seen on the fetch bus
//   - fc_state_e        : FSM state encodings (also visible on state_out)
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int STATE_BITS = 3;

    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [STATE_BITS-1:0] {
        FC_IDLE      = 3'd0,
        FC_LOAD      = 3'd1,
        FC_RUN       = 3'd2,
        FC_STEP_WAIT = 3'd3,
        FC_STEP_EXEC = 3'd4,
        FC_DRAIN     = 3'd5,
        FC_HALTED    = 3'd6
    } fc_state_e;

endpackage

// File: rtl/fetch_ctrl_drain_counter.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_drain_counter
// Loadable down-counter with zero flag, used to time the pipeline drain after
// a HALT word has been fetched.
// Ports:
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low
//   load_i      in   load load_val_i (takes priority over decrement)
//   load_val_i  in   value to load
//   dec_i       in   decrement by one (saturates at zero)
//   zero_o      out  count is zero
// -----------------------------------------------------------------------------
module fetch_ctrl_drain_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, decrement stops at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != {W{1'b0}})) begin
            count_d = count_q - {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == {W{1'b0}});

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Run/step sequencer for the instruction-fetch stage. Drives pc_reset and
// pc_enable of the fetch unit from operator commands (load, run, step), merges
// the hazard stall, detects the HALT word, drains the pipe and reports halt
// status plus an executed-cycle count.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   load_req             program memory being written; holds fetch in reset
//   run_cmd / step_cmd   start continuous run / advance one instruction
//   clear_cmd            leave HALTED, return to IDLE
//   stall_in             hazard-unit stall request
//   instr_in             fetched instruction
//   pc_reset, pc_enable  PC control (never both high)
//   drain, halted        status flags
//   step_done            one-cycle pulse after a step's PC advance
//   cycle_count          executed-cycle counter (RUN/STEP_EXEC/DRAIN cycles)
//   state_out            current state encoding
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = DATA_WIDTH'(DEFAULT_HALT_WORD),
    parameter int                    DRAIN_CYCLES = 4,
    parameter int                    CNT_BITS     = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_req,
    input  logic                  run_cmd,
    input  logic                  step_cmd,
    input  logic                  clear_cmd,
    input  logic                  stall_in,
    input  logic [DATA_WIDTH-1:0] instr_in,
    output logic                  pc_reset,
    output logic                  pc_enable,
    output logic                  drain,
    output logic                  halted,
    output logic                  step_done,
    output logic [CNT_BITS-1:0]   cycle_count,
    output logic [STATE_BITS-1:0] state_out
);

    localparam int DC_W = $clog2(DRAIN_CYCLES + 1);

    fc_state_e             state_q;
    fc_state_e             state_d;
    logic [CNT_BITS-1:0]   count_q;
    logic [CNT_BITS-1:0]   count_d;
    logic                  pc_reset_q;
    logic                  drain_q;
    logic                  halted_q;
    logic                  step_done_q;
    logic                  step_done_d;

    logic                  fetching_s;
    logic                  halt_word_s;
    logic                  halt_hit_s;
    logic                  drain_load_s;
    logic                  drain_dec_s;
    logic                  drain_zero_s;

    assign fetching_s  = (state_q == FC_RUN) || (state_q == FC_STEP_EXEC);
    assign halt_word_s = (instr_in == HALT_WORD);
    // A stalled HALT word is not yet a real fetch; only act on it once it issues.
    assign halt_hit_s  = fetching_s && halt_word_s && !stall_in;

    // The drain counter is primed on the HALT-detect cycle so the first DRAIN
    // cycle already holds DRAIN_CYCLES-1.
    assign drain_load_s = halt_hit_s;
    assign drain_dec_s  = (state_q == FC_DRAIN);

    fetch_ctrl_drain_counter #(
        .W (DC_W)
    ) u_drain_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (drain_load_s),
        .load_val_i (DC_W'(DRAIN_CYCLES - 1)),
        .dec_i      (drain_dec_s),
        .zero_o     (drain_zero_s)
    );

    // Next-state and step-completion logic.
    always_comb begin
        state_d     = state_q;
        step_done_d = 1'b0;
        case (state_q)
            FC_IDLE: begin
                if (load_req) begin
                    state_d = FC_LOAD;
                end else if (run_cmd) begin
                    state_d = FC_RUN;
                end else if (step_cmd) begin
                    state_d = FC_STEP_WAIT;
                end else begin
                    state_d = FC_IDLE;
                end
            end
            FC_LOAD: begin
                if (load_req) begin
                    state_d = FC_LOAD;
                end else begin
                    state_d = FC_IDLE;
                end
            end
            FC_RUN: begin
                if (halt_hit_s) begin
                    state_d = FC_DRAIN;
                end else if (step_cmd) begin
                    state_d = FC_STEP_WAIT;
                end else begin
                    state_d = FC_RUN;
                end
            end
            FC_STEP_WAIT: begin
                if (run_cmd) begin
                    state_d = FC_RUN;
                end else if (step_cmd) begin
                    state_d = FC_STEP_EXEC;
                end else begin
                    state_d = FC_STEP_WAIT;
                end
            end
            FC_STEP_EXEC: begin
                // HALT outranks step completion: no step_done on the halt cycle.
                if (halt_hit_s) begin
                    state_d = FC_DRAIN;
                end else if (!stall_in) begin
                    state_d     = FC_STEP_WAIT;
                    step_done_d = 1'b1;
                end else begin
                    state_d = FC_STEP_EXEC;
                end
            end
            FC_DRAIN: begin
                if (drain_zero_s) begin
                    state_d = FC_HALTED;
                end else begin
                    state_d = FC_DRAIN;
                end
            end
            FC_HALTED: begin
                if (clear_cmd) begin
                    state_d = FC_IDLE;
                end else begin
                    state_d = FC_HALTED;
                end
            end
            default: begin
                state_d = FC_IDLE;
            end
        endcase
    end

    // Executed-cycle counter next value; stalled cycles still count.
    always_comb begin
        count_d = count_q;
        case (state_q)
            FC_IDLE:                            count_d = {CNT_BITS{1'b0}};
            FC_RUN, FC_STEP_EXEC, FC_DRAIN:     count_d = count_q + CNT_BITS'(1'b1);
            default:                            count_d = count_q;
        endcase
    end

    // State, counter and registered Moore outputs (decoded from next state).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FC_IDLE;
            count_q     <= {CNT_BITS{1'b0}};
            pc_reset_q  <= 1'b1;
            drain_q     <= 1'b0;
            halted_q    <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pc_reset_q  <= (state_d == FC_IDLE) || (state_d == FC_LOAD);
            drain_q     <= (state_d == FC_DRAIN);
            halted_q    <= (state_d == FC_HALTED);
            step_done_q <= step_done_d;
        end
    end

    // pc_enable is the only combinational output: it must drop in the same
    // cycle as a stall or a HALT word so the PC never passes the HALT.
    assign pc_enable   = fetching_s && !stall_in && !halt_word_s;

    assign pc_reset    = pc_reset_q;
    assign drain       = drain_q;
    assign halted      = halted_q;
    assign step_done   = step_done_q;
    assign cycle_count = count_q;
    assign state_out   = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed self-checking bench for fetch_ctrl. Inputs change 1 time unit after
// the rising edge; outputs are checked 2 time units after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        load_req;
    logic        run_cmd;
    logic        step_cmd;
    logic        clear_cmd;
    logic        stall_in;
    logic [31:0] instr_in;
    logic        pc_reset;
    logic        pc_enable;
    logic        drain;
    logic        halted;
    logic        step_done;
    logic [31:0] cycle_count;
    logic [2:0]  state_out;

    int vecs;
    int errs;
    logic mon_on;
    int   sd_cnt;
    int   pe_cnt;

    fetch_ctrl #(
        .DATA_WIDTH   (32),
        .HALT_WORD    (32'hFFFF_FFFF),
        .DRAIN_CYCLES (4),
        .CNT_BITS     (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_req    (load_req),
        .run_cmd     (run_cmd),
        .step_cmd    (step_cmd),
        .clear_cmd   (clear_cmd),
        .stall_in    (stall_in),
        .instr_in    (instr_in),
        .pc_reset    (pc_reset),
        .pc_enable   (pc_enable),
        .drain       (drain),
        .halted      (halted),
        .step_done   (step_done),
        .cycle_count (cycle_count),
        .state_out   (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle tally of step_done pulses and PC advances during the step test.
    always @(negedge clk) begin
        if (mon_on) begin
            sd_cnt <= sd_cnt + int'(step_done);
            pe_cnt <= pe_cnt + int'(pc_enable);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] exp);
        chk(tag, {29'd0, state_out}, {29'd0, exp});
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        chk(tag, {31'd0, obs}, {31'd0, exp});
    endtask

    initial begin
        vecs = 0; errs = 0; mon_on = 1'b0; sd_cnt = 0; pe_cnt = 0;
        reset = 1'b0; load_req = 1'b0; run_cmd = 1'b0; step_cmd = 1'b0;
        clear_cmd = 1'b0; stall_in = 1'b0; instr_in = 32'h0000_0013;

        // 1: reset held low for two cycles
        tick(); tick(); settle();
        chk_state("rst_state", 3'd0);
        chk_bit("rst_pc_reset", pc_reset, 1'b1);
        chk_bit("rst_pc_enable", pc_enable, 1'b0);
        chk("rst_count", cycle_count, 32'd0);
        chk_bit("rst_drain", drain, 1'b0);
        chk_bit("rst_halted", halted, 1'b0);
        chk_bit("rst_step_done", step_done, 1'b0);

        // 2: load for 5 cycles, back to IDLE, then run
        reset = 1'b1; load_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_state("load_state", 3'd1);
            chk_bit("load_pc_reset", pc_reset, 1'b1);
        end
        load_req = 1'b0;
        tick();
        chk_state("load_exit_idle", 3'd0);
        run_cmd = 1'b1;
        tick();
        run_cmd = 1'b0; settle();
        chk_state("run_state", 3'd2);
        chk_bit("run_pc_reset", pc_reset, 1'b0);
        chk_bit("run_pc_enable", pc_enable, 1'b1);
        for (int i = 0; i < 10; i++) tick();
        chk("run_count10", cycle_count, 32'd10);

        // 3: stall for 3 cycles in RUN, counter keeps counting
        stall_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk_bit("stall_pc_enable", pc_enable, 1'b0);
            tick();
        end
        stall_in = 1'b0; settle();
        chk("stall_count13", cycle_count, 32'd13);
        chk_bit("stall_release_pc_enable", pc_enable, 1'b1);

        // 4: pause into step mode, then three steps (second stalled 2 cycles)
        step_cmd = 1'b1;
        tick();
        step_cmd = 1'b0; settle();
        chk_state("pause_step_wait", 3'd3);
        chk_bit("wait_pc_enable", pc_enable, 1'b0);
        chk("pause_count14", cycle_count, 32'd14);
        mon_on = 1'b1;
        // step 1
        step_cmd = 1'b1; tick(); step_cmd = 1'b0; settle();
        chk_state("step1_exec", 3'd4);
        chk_bit("step1_pc_enable", pc_enable, 1'b1);
        tick();
        chk_state("step1_back_wait", 3'd3);
        chk_bit("step1_done", step_done, 1'b1);
        tick();
        chk_bit("step1_done_pulse_end", step_done, 1'b0);
        // step 2 with 2 stalled cycles
        step_cmd = 1'b1; tick(); step_cmd = 1'b0; stall_in = 1'b1; settle();
        chk_bit("step2_stall_pc_enable", pc_enable, 1'b0);
        tick(); tick();
        chk_state("step2_still_exec", 3'd4);
        chk_bit("step2_no_done_yet", step_done, 1'b0);
        stall_in = 1'b0; settle();
        chk_bit("step2_pc_enable", pc_enable, 1'b1);
        tick();
        chk_bit("step2_done", step_done, 1'b1);
        tick();
        // step 3
        step_cmd = 1'b1; tick(); step_cmd = 1'b0;
        tick();
        chk_bit("step3_done", step_done, 1'b1);
        tick();
        mon_on = 1'b0;
        chk("step_done_pulses", sd_cnt, 32'd3);
        chk("step_pc_advances", pe_cnt, 32'd3);
        chk("step_count19", cycle_count, 32'd19);

        // 5: HALT word in RUN -> drain 4 cycles -> HALTED -> clear
        run_cmd = 1'b1; tick(); run_cmd = 1'b0;
        chk_state("resume_run", 3'd2);
        instr_in = 32'hFFFF_FFFF; settle();
        chk_bit("halt_detect_pc_enable", pc_enable, 1'b0);
        tick();
        instr_in = 32'h0000_0013;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk_state("drain_state", 3'd5);
            chk_bit("drain_flag", drain, 1'b1);
            chk_bit("drain_pc_enable", pc_enable, 1'b0);
            tick();
        end
        chk_state("halted_state", 3'd6);
        chk_bit("halted_flag", halted, 1'b1);
        chk_bit("halted_drain_low", drain, 1'b0);
        chk("halted_count24", cycle_count, 32'd24);
        run_cmd = 1'b1; step_cmd = 1'b1; load_req = 1'b1;
        tick();
        run_cmd = 1'b0; step_cmd = 1'b0; load_req = 1'b0;
        chk_state("halted_ignores_cmds", 3'd6);
        chk("halted_count_hold", cycle_count, 32'd24);
        clear_cmd = 1'b1; tick(); clear_cmd = 1'b0;
        chk_state("clear_to_idle", 3'd0);
        chk_bit("clear_pc_reset", pc_reset, 1'b1);
        chk_bit("clear_halted_low", halted, 1'b0);
        tick();
        chk("idle_count_cleared", cycle_count, 32'd0);

        // 6: reset during DRAIN, then run+step together from IDLE
        run_cmd = 1'b1; tick(); run_cmd = 1'b0;
        instr_in = 32'hFFFF_FFFF; tick(); instr_in = 32'h0000_0013;
        tick();
        chk_state("pre_reset_drain", 3'd5);
        reset = 1'b0; tick(); reset = 1'b1;
        chk_state("drain_reset_idle", 3'd0);
        chk("drain_reset_count", cycle_count, 32'd0);
        chk_bit("drain_reset_drain_low", drain, 1'b0);
        chk_bit("drain_reset_pc_reset", pc_reset, 1'b1);
        run_cmd = 1'b1; step_cmd = 1'b1; tick(); run_cmd = 1'b0; step_cmd = 1'b0;
        chk_state("idle_run_priority", 3'd2);
        load_req = 1'b1; tick(); load_req = 1'b0;
        chk_state("run_ignores_load", 3'd2);
        chk_bit("run_ignores_load_pc_reset", pc_reset, 1'b0);

        // Extra: run wins in STEP_WAIT; HALT in STEP_EXEC suppresses step_done
        step_cmd = 1'b1; tick(); step_cmd = 1'b0;
        chk_state("run_to_wait", 3'd3);
        run_cmd = 1'b1; step_cmd = 1'b1; tick(); run_cmd = 1'b0; step_cmd = 1'b0;
        chk_state("wait_run_priority", 3'd2);
        step_cmd = 1'b1; tick(); tick(); step_cmd = 1'b0;
        chk_state("exec_for_halt", 3'd4);
        instr_in = 32'hFFFF_FFFF; settle();
        chk_bit("exec_halt_pc_enable", pc_enable, 1'b0);
        tick(); instr_in = 32'h0000_0013;
        chk_state("exec_halt_drain", 3'd5);
        chk_bit("exec_halt_no_step_done", step_done, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
